// File: rtl/wb_lsu.sv
// wb_lsu - RV32 load/store unit bridging the core data port to a pipelined
// Wishbone slave (block_ram). One request is in flight at a time; each one
// becomes a single Wishbone cycle. Load data comes back lane-aligned and
// sign/zero-extended. Illegal funct3 codes and bus timeouts are reported
// through o_rsp_err.
//
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_req_*/o_req_ready      core request (valid/ready, we, addr, wdata, funct3)
//   o_rsp_valid/rdata/err    one-cycle response pulse, no backpressure
//   o_wb_*                   Wishbone master outputs (cyc, stb, we, addr, data, sel)
//   i_wb_data/stall/ack      Wishbone slave responses
//
// Parameters:
//   XLEN     data/address width (only 32 is supported)
//   TIMEOUT  cycles to wait for ack once the strobe is taken; 0 waits forever
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses return
//                         err=1 without touching the bus. When undefined they
//                         are issued (a word access has its low address bits
//                         dropped).
module wb_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic [2:0]      i_req_funct3,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [XLEN-1:0] o_wb_addr,
  output logic [XLEN-1:0] o_wb_data,
  output logic [3:0]      o_wb_sel,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Counter value on the last WAIT cycle before giving up.
  localparam logic [31:0] TO_LAST_C = 32'(TIMEOUT) - 32'd1;

  state_t      state_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [31:0] cnt_r;

  logic [1:0]  off_s;
  logic [3:0]  sel_s;
  logic [31:0] data_s;
  logic        illegal_s;
  logic        misalign_s;

  // Shift the addressed lanes down to bit 0 and extend according to funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b010:  load_extend = sh;
      3'b100:  load_extend = {24'd0, sh[7:0]};
      3'b101:  load_extend = {16'd0, sh[15:0]};
      default: load_extend = 32'd0;
    endcase
  endfunction

  assign o_req_ready = (state_r == S_IDLE);

  // Decode the incoming request into byte lanes, replicated store data and error flags.
  always_comb begin
    off_s  = i_req_addr[1:0];
    sel_s  = 4'b0000;
    data_s = 32'd0;
    case (i_req_funct3[1:0])
      2'b00: begin
        sel_s  = 4'b0001 << i_req_addr[1:0];
        data_s = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        // Offset 3 pushes the upper lane off the end: only lane 3 is enabled.
        sel_s  = 4'b0011 << i_req_addr[1:0];
        data_s = {2{i_req_wdata[15:0]}};
      end
      2'b10: begin
        // Words always use all lanes; a misaligned word address is truncated.
        sel_s  = 4'b1111;
        data_s = i_req_wdata;
        off_s  = 2'b00;
      end
      default: begin
        sel_s  = 4'b0000;
        data_s = 32'd0;
      end
    endcase
    // x11 never exists; 1xx exists only for byte/half loads.
    illegal_s = (i_req_funct3[1:0] == 2'b11) ||
                (i_req_funct3[2] && (i_req_we || (i_req_funct3[1:0] == 2'b10)));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_s = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                 ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
  end

  // Request/bus/response state machine with registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= S_IDLE;
      f3_r        <= 3'b000;
      off_r       <= 2'b00;
      cnt_r       <= 32'd0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= 32'd0;
      o_wb_data   <= 32'd0;
      o_wb_sel    <= 4'b0000;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_req_valid) begin
            f3_r  <= i_req_funct3;
            off_r <= off_s;
            if (illegal_s || misalign_s) begin
              state_r     <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= 32'd0;
            end else begin
              state_r   <= S_REQ;
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_req_we;
              o_wb_addr <= {i_req_addr[31:2], 2'b00};
              o_wb_data <= data_s;
              o_wb_sel  <= sel_s;
            end
          end
        end
        S_REQ: begin
          // While stalled, everything presented on the bus stays put.
          if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            if (i_wb_ack) begin
              state_r     <= S_RESP;
              o_wb_cyc    <= 1'b0;
              o_wb_we     <= 1'b0;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b0;
              o_rsp_rdata <= o_wb_we ? 32'd0 : load_extend(i_wb_data, off_r, f3_r);
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= 32'd0;
            end
          end
        end
        S_WAIT: begin
          // An ack in the timeout cycle still completes normally.
          if (i_wb_ack) begin
            state_r     <= S_RESP;
            o_wb_cyc    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= o_wb_we ? 32'd0 : load_extend(i_wb_data, off_r, f3_r);
          end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST_C)) begin
            state_r     <= S_RESP;
            o_wb_cyc    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= 32'd0;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu.sv
// tb_wb_lsu - self-checking bench for wb_lsu. Expected responses are queued
// when a request is driven and compared when o_rsp_valid pulses; bus-side
// signals are checked cycle by cycle while the access runs.
module tb_wb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_dout;
  logic [3:0]  wb_sel;
  logic [31:0] wb_din;
  logic        wb_stall;
  logic        wb_ack;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] sb_q[$];     // {err, rdata}
  logic [32:0] sb_exp;

  wb_lsu #(.XLEN(32), .TIMEOUT(15)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_funct3 (req_funct3),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_dout),
    .o_wb_sel     (wb_sel),
    .i_wb_data    (wb_din),
    .i_wb_stall   (wb_stall),
    .i_wb_ack     (wb_ack)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      check_val("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        check_val("rsp_rdata", rsp_rdata, sb_exp[31:0]);
        check_val("rsp_err", 32'(rsp_err), 32'(sb_exp[32]));
      end
    end
  end

  // Drive one request and act as the slave. bus=0 means no cycle is expected.
  task automatic run_acc(input string nm, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3, input logic bus,
                         input logic [3:0] xsel, input logic [31:0] xdata,
                         input logic [31:0] sdata, input int nstall, input logic ack,
                         input logic [31:0] xrdata, input logic xerr);
    int waited;
    check_val({nm, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    sb_q.push_back({xerr, xrdata});
    @(negedge clk);
    req_valid = 1'b0;
    if (!bus) begin
      check_val({nm, "_nocyc"}, 32'(wb_cyc), 32'd0);
      check_val({nm, "_rsp_lat"}, 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end else begin
      for (int k = 0; k <= nstall; k++) begin
        wb_stall = (k < nstall);
        check_val({nm, "_cyc"}, 32'(wb_cyc), 32'd1);
        check_val({nm, "_stb"}, 32'(wb_stb), 32'd1);
        check_val({nm, "_we"}, 32'(wb_we), 32'(we));
        check_val({nm, "_addr"}, wb_addr, addr & 32'hFFFF_FFFC);
        check_val({nm, "_sel"}, 32'(wb_sel), 32'(xsel));
        check_val({nm, "_data"}, wb_dout, xdata);
        @(negedge clk);
      end
      wb_stall = 1'b0;
      check_val({nm, "_stb_drop"}, 32'(wb_stb), 32'd0);
      check_val({nm, "_cyc_wait"}, 32'(wb_cyc), 32'd1);
      if (ack) begin
        wb_ack = 1'b1;
        wb_din = sdata;
        @(negedge clk);
        wb_ack = 1'b0;
        wb_din = 32'd0;
        check_val({nm, "_rsp_lat"}, 32'(rsp_valid), 32'd1);
        check_val({nm, "_cyc_end"}, 32'(wb_cyc), 32'd0);
        @(negedge clk);
      end else begin
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 40) begin
          @(negedge clk);
          waited++;
        end
        check_val({nm, "_timeout_cycles"}, 32'(waited), 32'd15);
        check_val({nm, "_cyc_end"}, 32'(wb_cyc), 32'd0);
        @(negedge clk);
      end
    end
    check_val({nm, "_ready_after"}, 32'(req_ready), 32'd1);
    check_val({nm, "_no_extra_rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_funct3 = 3'b000;
    wb_din     = 32'd0;
    wb_stall   = 1'b0;
    wb_ack     = 1'b0;

    #2;
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_cyc", 32'(wb_cyc), 32'd0);
    check_val("rst_stb", 32'(wb_stb), 32'd0);
    check_val("rst_we", 32'(wb_we), 32'd0);
    check_val("rst_addr", wb_addr, 32'd0);
    check_val("rst_data", wb_dout, 32'd0);
    check_val("rst_sel", 32'(wb_sel), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //       name      we    addr        wdata         f3     bus   sel      wb data       slave data    st ack   rdata         err
    run_acc("sw",      1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 1'b1, 32'h0,        1'b0);
    run_acc("lb",      1'b0, 32'h13, 32'h0,        3'b000, 1'b1, 4'b1000, 32'h0,        32'h80FF1234, 0, 1'b1, 32'hFFFFFF80, 1'b0);
    run_acc("lbu",     1'b0, 32'h13, 32'h0,        3'b100, 1'b1, 4'b1000, 32'h0,        32'h80FF1234, 0, 1'b1, 32'h00000080, 1'b0);
    run_acc("lhu",     1'b0, 32'h12, 32'h0,        3'b101, 1'b1, 4'b1100, 32'h0,        32'h80FF1234, 0, 1'b1, 32'h000080FF, 1'b0);
    run_acc("lh",      1'b0, 32'h02, 32'h0,        3'b001, 1'b1, 4'b1100, 32'h0,        32'h80017FFF, 0, 1'b1, 32'hFFFF8001, 1'b0);
    run_acc("sb",      1'b1, 32'h31, 32'h000000A5, 3'b000, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 1'b1, 32'h0,        1'b0);
    run_acc("sh_stl",  1'b1, 32'h22, 32'h0000ABCD, 3'b001, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0,        3, 1'b1, 32'h0,        1'b0);
    run_acc("lw_to",   1'b0, 32'h40, 32'h0,        3'b010, 1'b1, 4'b1111, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1);
    run_acc("ld_011",  1'b0, 32'h44, 32'h0,        3'b011, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1);
    run_acc("st_100",  1'b1, 32'h44, 32'h12345678, 3'b100, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1);
    run_acc("ld_110",  1'b0, 32'h48, 32'h0,        3'b110, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
    run_acc("lw_mis",  1'b0, 32'h21, 32'h0,        3'b010, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1);
    run_acc("lh_mis",  1'b0, 32'h13, 32'h00005A3C, 3'b001, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1);
`else
    run_acc("lw_mis",  1'b0, 32'h21, 32'h0,        3'b010, 1'b1, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 1'b0);
    run_acc("lh_mis",  1'b0, 32'h13, 32'h00005A3C, 3'b001, 1'b1, 4'b1000, 32'h5A3C5A3C, 32'hAB000000, 0, 1'b1, 32'h000000AB, 1'b0);
`endif

    // Reset while the LSU waits for an ack: the cycle must vanish with no response.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h50;
    req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("rstw_pre_cyc", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstw_cyc", 32'(wb_cyc), 32'd0);
    check_val("rstw_stb", 32'(wb_stb), 32'd0);
    check_val("rstw_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_acc("lw_post", 1'b0, 32'h30, 32'h0,        3'b010, 1'b1, 4'b1111, 32'h0,        32'h12345678, 0, 1'b1, 32'h12345678, 1'b0);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
